// File: rtl/pc_sequencer_ras_pkg.sv
// -----------------------------------------------------------------------------
// pc_sequencer_ras_pkg
// Purpose : shared types and defaults for the next-PC unit and its
//           return-address stack.
// Contents: PC_W / RESET_PC_DEF defaults, ras_op_e (stack operation),
//           pc_sel_e (next-PC source select).
// -----------------------------------------------------------------------------
package pc_sequencer_ras_pkg;

   localparam int              PC_W         = 16;
   localparam logic [PC_W-1:0] RESET_PC_DEF = '0;

   typedef enum logic [1:0] {
      RAS_NOP,
      RAS_PUSH,
      RAS_POP
   } ras_op_e;

   typedef enum logic [2:0] {
      SEL_SEQ,     // pc_out + 1
      SEL_HOLD,    // fetch stalled
      SEL_BRANCH,  // execute-stage redirect
      SEL_RET,     // RAS top (or pc_out + 1 on underflow)
      SEL_CALL,    // jmp_target_d, pushes pc_d + 1
      SEL_JMP,     // jmp_target_d
      SEL_FOR      // for_target_d, pushes pc_d
   } pc_sel_e;

endpackage

// File: rtl/pc_sequencer_ras_if.sv
// -----------------------------------------------------------------------------
// pc_sequencer_ras_if
// Purpose : bundles the pipeline control inputs and PC/RAS status outputs of
//           the next-PC unit.
// Modports: master - hazard/decode/execute control (drives controls, reads PC)
//           slave  - pc_sequencer_ras (reads controls, drives PC and status)
// -----------------------------------------------------------------------------
interface pc_sequencer_ras_if
   import pc_sequencer_ras_pkg::*;
#(
   parameter int WIDTH = PC_W,
   parameter int DEPTH = 4
);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic             stall_f;
   logic             stall_d;
   logic             flush_d;
   logic             jmp_d;
   logic             call_d;
   logic             ret_d;
   logic             for_d;
   logic [WIDTH-1:0] jmp_target_d;
   logic [WIDTH-1:0] for_target_d;
   logic             branch_taken_e;
   logic [WIDTH-1:0] branch_target_e;

   logic [WIDTH-1:0] pc_out;
   logic [WIDTH-1:0] pc_d;
   logic             pc_d_valid;
   logic [CNT_W-1:0] ras_depth;
   logic             ras_empty;
   logic             ras_full;
   logic             ras_ovf;
   logic             ras_unf;

   modport master (
      output stall_f, stall_d, flush_d, jmp_d, call_d, ret_d, for_d,
             jmp_target_d, for_target_d, branch_taken_e, branch_target_e,
      input  pc_out, pc_d, pc_d_valid, ras_depth, ras_empty, ras_full,
             ras_ovf, ras_unf
   );

   modport slave (
      input  stall_f, stall_d, flush_d, jmp_d, call_d, ret_d, for_d,
             jmp_target_d, for_target_d, branch_taken_e, branch_target_e,
      output pc_out, pc_d, pc_d_valid, ras_depth, ras_empty, ras_full,
             ras_ovf, ras_unf
   );

endinterface

// File: rtl/pc_sequencer_ras_stack.sv
// -----------------------------------------------------------------------------
// pc_sequencer_ras_stack
// Purpose : DEPTH-entry return-address stack held in a circular buffer.
//           wr_ptr is the next free slot; the top entry sits just below it.
//           When full, wr_ptr points at the oldest entry, so overwrite mode
//           simply writes there and advances.
// Ports   : clk, rst (sync, active-low), op (NOP/PUSH/POP), push_val,
//           top (current top entry), depth, full, empty,
//           ovf_pulse (push while full), unf_pulse (pop while empty).
// -----------------------------------------------------------------------------
module pc_sequencer_ras_stack
   import pc_sequencer_ras_pkg::*;
#(
   parameter int WIDTH    = PC_W,
   parameter int DEPTH    = 4,
   parameter int OVF_MODE = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  ras_op_e                    op,
   input  logic [WIDTH-1:0]           push_val,
   output logic [WIDTH-1:0]           top,
   output logic [$clog2(DEPTH+1)-1:0] depth,
   output logic                       full,
   output logic                       empty,
   output logic                       ovf_pulse,
   output logic                       unf_pulse
);
   localparam int               CNT_W    = $clog2(DEPTH + 1);
   localparam int               PTR_W    = $clog2(DEPTH);
   localparam logic [PTR_W-1:0] LAST     = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] top_ptr;
   logic [PTR_W-1:0] next_ptr;
   logic             do_write;

   // Explicit wrap keeps non-power-of-two depths correct.
   assign top_ptr  = (wr_ptr == '0)   ? LAST : wr_ptr - 1'b1;
   assign next_ptr = (wr_ptr == LAST) ? '0   : wr_ptr + 1'b1;

   assign full      = (depth == FULL_CNT);
   assign empty     = (depth == '0);
   assign top       = mem[top_ptr];
   assign ovf_pulse = (op == RAS_PUSH) && full;
   assign unf_pulse = (op == RAS_POP)  && empty;
   assign do_write  = (op == RAS_PUSH) && (!full || (OVF_MODE != 0));

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         depth  <= '0;
         // NOTE: the entries are cleared on reset so a post-reset stack reads
         // back deterministic zeros; drop this loop if the storage has to map
         // onto a RAM macro without a reset port.
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (do_write) begin
         mem[wr_ptr] <= push_val;
         wr_ptr      <= next_ptr;
         if (!full) depth <= depth + 1'b1;
      end else if ((op == RAS_POP) && !empty) begin
         wr_ptr <= top_ptr;
         depth  <= depth - 1'b1;
      end
   end

endmodule

// File: rtl/pc_sequencer_ras.sv
// -----------------------------------------------------------------------------
// pc_sequencer_ras
// Purpose : next-PC unit. Owns the fetch PC and the decode-stage PC, resolves
//           execute branches and decode jump/call/return/for-loop redirects by
//           fixed priority, and keeps return addresses in a DEPTH-entry RAS.
// Ports   : clk, rst (sync, active-low)
//           bus (slave): stall/flush controls, decode ops and targets,
//           execute branch; pc_out, pc_d, pc_d_valid, RAS depth/full/empty
//           and sticky ovf/unf flags.
// -----------------------------------------------------------------------------
module pc_sequencer_ras
   import pc_sequencer_ras_pkg::*;
#(
   parameter int               WIDTH    = PC_W,
   parameter int               DEPTH    = 4,
   parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEF),
   parameter int               OVF_MODE = 0
) (
   input logic               clk,
   input logic               rst,
   pc_sequencer_ras_if.slave bus
);
   logic             dec_act;
   pc_sel_e          sel;
   ras_op_e          op;
   logic [WIDTH-1:0] push_val;
   logic [WIDTH-1:0] pc_inc;
   logic [WIDTH-1:0] pc_next;
   logic [WIDTH-1:0] ras_top;
   logic             ovf_pulse;
   logic             unf_pulse;

   // A taken branch means the decode slot is on the wrong path.
   assign dec_act = bus.pc_d_valid & ~bus.stall_d & ~bus.branch_taken_e;
   assign pc_inc  = bus.pc_out + 1'b1;

   // Source selection. stall_f only holds the sequential fetch: a qualified
   // decode op has already been accepted (and may have touched the RAS), so
   // its redirect must not be lost.
   always_comb begin
      // NOTE: every output gets a default before the if-chain so no path
      // leaves a value unassigned, which would infer a latch.
      sel      = SEL_SEQ;
      op       = RAS_NOP;
      push_val = '0;
      if (bus.branch_taken_e) begin
         sel = SEL_BRANCH;
      end else if (dec_act && bus.ret_d) begin
         sel = SEL_RET;
         op  = RAS_POP;
      end else if (dec_act && bus.call_d) begin
         sel      = SEL_CALL;
         op       = RAS_PUSH;
         push_val = bus.pc_d + 1'b1;
      end else if (dec_act && bus.jmp_d) begin
         sel = SEL_JMP;
      end else if (dec_act && bus.for_d) begin
         sel      = SEL_FOR;
         op       = RAS_PUSH;
         push_val = bus.pc_d;
      end else if (bus.stall_f) begin
         sel = SEL_HOLD;
      end
   end

   always_comb begin
      pc_next = pc_inc;
      unique case (sel)
         SEL_BRANCH:       pc_next = bus.branch_target_e;
         SEL_RET:          pc_next = bus.ras_empty ? pc_inc : ras_top;
         SEL_CALL,
         SEL_JMP:          pc_next = bus.jmp_target_d;
         SEL_FOR:          pc_next = bus.for_target_d;
         SEL_HOLD:         pc_next = bus.pc_out;
         default:          pc_next = pc_inc;
      endcase
   end

   pc_sequencer_ras_stack #(
      .WIDTH    (WIDTH),
      .DEPTH    (DEPTH),
      .OVF_MODE (OVF_MODE)
   ) u_stack (
      .clk       (clk),
      .rst       (rst),
      .op        (op),
      .push_val  (push_val),
      .top       (ras_top),
      .depth     (bus.ras_depth),
      .full      (bus.ras_full),
      .empty     (bus.ras_empty),
      .ovf_pulse (ovf_pulse),
      .unf_pulse (unf_pulse)
   );

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values of the others (pc_d takes the old pc_out).
      if (!rst) begin
         bus.pc_out     <= RESET_PC;
         bus.pc_d       <= RESET_PC;
         bus.pc_d_valid <= 1'b0;
         bus.ras_ovf    <= 1'b0;
         bus.ras_unf    <= 1'b0;
      end else begin
         bus.pc_out <= pc_next;
         if (!bus.stall_d) begin
            bus.pc_d       <= bus.pc_out;
            bus.pc_d_valid <= ~bus.flush_d & ~bus.branch_taken_e;
         end else if (bus.flush_d) begin
            bus.pc_d_valid <= 1'b0;   // flush still kills a stalled slot
         end
         bus.ras_ovf <= bus.ras_ovf | ovf_pulse;
         bus.ras_unf <= bus.ras_unf | unf_pulse;
      end
   end

endmodule

// File: tb/tb_pc_sequencer_ras.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer_ras
// Two instances share stimulus: dut0 drops pushes on a full stack, dut1
// overwrites the oldest entry. Table vectors exercise dut0; the overflow
// sequence compares both.
// -----------------------------------------------------------------------------
module tb_pc_sequencer_ras;

   localparam int W = 16;
   localparam int D = 4;

   // control bits: {stall_f, stall_d, flush_d, branch_taken_e}
   localparam logic [3:0] NO = 4'b0000;
   localparam logic [3:0] SF = 4'b1000;
   localparam logic [3:0] SD = 4'b0100;
   localparam logic [3:0] FL = 4'b0010;
   localparam logic [3:0] BR = 4'b0001;

   typedef enum logic [2:0] {DN, DJ, DC, DR, DF} dop_e;

   typedef struct {
      logic        rst;
      logic [3:0]  ctl;
      dop_e        op;
      logic [15:0] tgt;
      logic [15:0] pc;
      logic [15:0] pcd;
      logic        vld;
      int          dep;
      logic        unf;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   n_vec = 0;
   int   n_err = 0;
   vec_t vecs[$];

   always #5 clk = ~clk;

   pc_sequencer_ras_if #(.WIDTH(W), .DEPTH(D)) b0 ();
   pc_sequencer_ras_if #(.WIDTH(W), .DEPTH(D)) b1 ();

   pc_sequencer_ras #(.WIDTH(W), .DEPTH(D), .RESET_PC(16'h0010), .OVF_MODE(0))
      dut0 (.clk(clk), .rst(rst), .bus(b0.slave));
   pc_sequencer_ras #(.WIDTH(W), .DEPTH(D), .RESET_PC(16'h0010), .OVF_MODE(1))
      dut1 (.clk(clk), .rst(rst), .bus(b1.slave));

   assign b1.stall_f         = b0.stall_f;
   assign b1.stall_d         = b0.stall_d;
   assign b1.flush_d         = b0.flush_d;
   assign b1.jmp_d           = b0.jmp_d;
   assign b1.call_d          = b0.call_d;
   assign b1.ret_d           = b0.ret_d;
   assign b1.for_d           = b0.for_d;
   assign b1.jmp_target_d    = b0.jmp_target_d;
   assign b1.for_target_d    = b0.for_target_d;
   assign b1.branch_taken_e  = b0.branch_taken_e;
   assign b1.branch_target_e = b0.branch_target_e;

   // Decode ops must be mutually exclusive.
   always @(posedge clk)
      if (rst)
         assert ($onehot0({b0.jmp_d, b0.call_d, b0.ret_d, b0.for_d}))
            else $error("decode ops asserted together");

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic [3:0] ctl, input dop_e op, input logic [15:0] tgt);
      rst                = r;
      b0.stall_f         = ctl[3];
      b0.stall_d         = ctl[2];
      b0.flush_d         = ctl[1];
      b0.branch_taken_e  = ctl[0];
      b0.jmp_d           = (op == DJ);
      b0.call_d          = (op == DC);
      b0.ret_d           = (op == DR);
      b0.for_d           = (op == DF);
      b0.jmp_target_d    = tgt;
      b0.for_target_d    = tgt;
      b0.branch_target_e = 16'h0200;
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(input logic r, input logic [3:0] ctl, input dop_e op,
                               input logic [15:0] tgt, input logic [15:0] pc,
                               input logic [15:0] pcd, input logic vld, input int dep,
                               input logic unf);
      vec_t v;
      v.rst = r; v.ctl = ctl; v.op = op; v.tgt = tgt; v.pc = pc; v.pcd = pcd;
      v.vld = vld; v.dep = dep; v.unf = unf;
      return v;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      // reset and free run
      vecs.push_back(mk(1'b0, NO, DN, 16'h0000, 16'h0010, 16'h0010, 1'b0, 0, 1'b0));
      vecs.push_back(mk(1'b1, NO, DN, 16'h0000, 16'h0011, 16'h0010, 1'b1, 0, 1'b0));
      vecs.push_back(mk(1'b1, NO, DN, 16'h0000, 16'h0012, 16'h0011, 1'b1, 0, 1'b0));
      // jump to 0x0004, walk to pc_d=0x0005, nested calls and returns
      vecs.push_back(mk(1'b1, FL, DJ, 16'h0004, 16'h0004, 16'h0012, 1'b0, 0, 1'b0));
      vecs.push_back(mk(1'b1, NO, DN, 16'h0000, 16'h0005, 16'h0004, 1'b1, 0, 1'b0));
      vecs.push_back(mk(1'b1, NO, DN, 16'h0000, 16'h0006, 16'h0005, 1'b1, 0, 1'b0));
      vecs.push_back(mk(1'b1, FL, DC, 16'h0040, 16'h0040, 16'h0006, 1'b0, 1, 1'b0));
      vecs.push_back(mk(1'b1, NO, DN, 16'h0000, 16'h0041, 16'h0040, 1'b1, 1, 1'b0));
      vecs.push_back(mk(1'b1, NO, DN, 16'h0000, 16'h0042, 16'h0041, 1'b1, 1, 1'b0));
      vecs.push_back(mk(1'b1, FL, DC, 16'h0080, 16'h0080, 16'h0042, 1'b0, 2, 1'b0));
      vecs.push_back(mk(1'b1, NO, DN, 16'h0000, 16'h0081, 16'h0080, 1'b1, 2, 1'b0));
      vecs.push_back(mk(1'b1, FL, DR, 16'h0000, 16'h0042, 16'h0081, 1'b0, 1, 1'b0));
      vecs.push_back(mk(1'b1, NO, DN, 16'h0000, 16'h0043, 16'h0042, 1'b1, 1, 1'b0));
      vecs.push_back(mk(1'b1, FL, DR, 16'h0000, 16'h0006, 16'h0043, 1'b0, 0, 1'b0));
      vecs.push_back(mk(1'b1, NO, DN, 16'h0000, 16'h0007, 16'h0006, 1'b1, 0, 1'b0));
      // call together with taken branch: branch wins, no push, slot killed
      vecs.push_back(mk(1'b1, BR, DC, 16'h0099, 16'h0200, 16'h0007, 1'b0, 0, 1'b0));
      vecs.push_back(mk(1'b1, NO, DN, 16'h0000, 16'h0201, 16'h0200, 1'b1, 0, 1'b0));
      // ret on empty stack at pc_out=0x0020
      vecs.push_back(mk(1'b1, NO, DJ, 16'h001F, 16'h001F, 16'h0201, 1'b1, 0, 1'b0));
      vecs.push_back(mk(1'b1, NO, DN, 16'h0000, 16'h0020, 16'h001F, 1'b1, 0, 1'b0));
      vecs.push_back(mk(1'b1, NO, DR, 16'h0000, 16'h0021, 16'h0020, 1'b1, 0, 1'b1));
      vecs.push_back(mk(1'b1, NO, DN, 16'h0000, 16'h0022, 16'h0021, 1'b1, 0, 1'b1));
      // for_d pushes pc_d (0x0021); stalled ret holds, single pop on release
      vecs.push_back(mk(1'b1, FL, DF, 16'h0030, 16'h0030, 16'h0022, 1'b0, 1, 1'b1));
      vecs.push_back(mk(1'b1, NO, DN, 16'h0000, 16'h0031, 16'h0030, 1'b1, 1, 1'b1));
      vecs.push_back(mk(1'b1, SF | SD, DR, 16'h0000, 16'h0031, 16'h0030, 1'b1, 1, 1'b1));
      vecs.push_back(mk(1'b1, SF | SD, DR, 16'h0000, 16'h0031, 16'h0030, 1'b1, 1, 1'b1));
      vecs.push_back(mk(1'b1, FL, DR, 16'h0000, 16'h0021, 16'h0031, 1'b0, 0, 1'b1));
      vecs.push_back(mk(1'b1, NO, DN, 16'h0000, 16'h0022, 16'h0021, 1'b1, 0, 1'b1));
      // stall_f alone; flush over stall_d
      vecs.push_back(mk(1'b1, SF, DN, 16'h0000, 16'h0022, 16'h0022, 1'b1, 0, 1'b1));
      vecs.push_back(mk(1'b1, SD | FL, DN, 16'h0000, 16'h0023, 16'h0022, 1'b0, 0, 1'b1));
      // mid-operation reset wins and clears the sticky flag
      vecs.push_back(mk(1'b0, BR, DC, 16'h0055, 16'h0010, 16'h0010, 1'b0, 0, 1'b0));

      foreach (vecs[i]) begin
         drive(vecs[i].rst, vecs[i].ctl, vecs[i].op, vecs[i].tgt);
         check($sformatf("v%0d pc_out", i),     32'(b0.pc_out),     32'(vecs[i].pc));
         check($sformatf("v%0d pc_d", i),       32'(b0.pc_d),       32'(vecs[i].pcd));
         check($sformatf("v%0d pc_d_valid", i), 32'(b0.pc_d_valid), 32'(vecs[i].vld));
         check($sformatf("v%0d ras_depth", i),  32'(b0.ras_depth),  32'(vecs[i].dep));
         check($sformatf("v%0d ras_empty", i),  32'(b0.ras_empty),  32'(vecs[i].dep == 0));
         check($sformatf("v%0d ras_unf", i),    32'(b0.ras_unf),    32'(vecs[i].unf));
      end

      // overflow: five calls push 0x0101..0x0105 into a 4-entry stack
      drive(1'b1, NO, DN, 16'h0000);
      drive(1'b1, NO, DJ, 16'h0100);
      drive(1'b1, NO, DN, 16'h0000);
      check("ovf setup pc_out", 32'(b0.pc_out), 32'h0101);
      for (int k = 1; k <= 5; k++) begin
         drive(1'b1, NO, DC, 16'(16'h0101 + k));
         check($sformatf("push%0d depth m0", k), 32'(b0.ras_depth), 32'((k > 4) ? 4 : k));
         check($sformatf("push%0d depth m1", k), 32'(b1.ras_depth), 32'((k > 4) ? 4 : k));
         check($sformatf("push%0d full m0", k),  32'(b0.ras_full),  32'(k >= 4));
         check($sformatf("push%0d ovf m0", k),   32'(b0.ras_ovf),   32'(k == 5));
         check($sformatf("push%0d ovf m1", k),   32'(b1.ras_ovf),   32'(k == 5));
      end
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, NO, DR, 16'h0000);
         check($sformatf("pop%0d pc m0", k),    32'(b0.pc_out),    32'(16'h0104 - k));
         check($sformatf("pop%0d pc m1", k),    32'(b1.pc_out),    32'(16'h0105 - k));
         check($sformatf("pop%0d depth m0", k), 32'(b0.ras_depth), 32'(3 - k));
         check($sformatf("pop%0d depth m1", k), 32'(b1.ras_depth), 32'(3 - k));
      end
      drive(1'b1, NO, DR, 16'h0000);
      check("unf pc m0",    32'(b0.pc_out),    32'h0102);
      check("unf pc m1",    32'(b1.pc_out),    32'h0103);
      check("unf flag m0",  32'(b0.ras_unf),   32'h1);
      check("unf flag m1",  32'(b1.ras_unf),   32'h1);
      check("unf empty m1", 32'(b1.ras_empty), 32'h1);
      check("unf depth m0", 32'(b0.ras_depth), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
